fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the program-counter register in the fetch stage. It drives the register's `en`, `clr` and `sd` inputs. It runs the request/response handshake with instruction memory and presents each fetched instruction to decode. It also merges branch and exception redirects into a single ordered PC update, so an outstanding fetch is never orphaned.

## Interface
Parameters:
- `WIDTH`, 32: address/instruction width.
- `RESET_PC`, 0: value held in `pc_sd` and `if_pc` out of reset.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall_i` in 1: decode cannot accept the instruction this cycle.
- `exc_valid` in 1: exception redirect request; single-cycle pulse.
- `exc_target` in WIDTH: exception vector.
- `br_valid` in 1: branch/jump redirect request; single-cycle pulse.
- `br_target` in WIDTH: branch target.
- `pc_q` in WIDTH: current PC register value.
- `pc_en` out 1: PC register load enable (sequential advance).
- `pc_clr` out 1: PC register redirect load.
- `pc_sd` out WIDTH: redirect value.
- `inst_req` out 1: fetch request.
- `inst_addr` out WIDTH: fetch address; equals `pc_q`.
- `inst_addr_ok` in 1: memory accepted the request.
- `inst_data_ok` in 1: fetch data valid.
- `inst_rdata` in WIDTH: fetch data.
- `if_valid` out 1: instruction valid to decode.
- `if_pc` out WIDTH: PC of the presented instruction.
- `if_inst` out WIDTH: the instruction.

## Operation
- States: IDLE, REQ, WAIT, VALID, REDIR.
- IDLE: entered on reset; unconditionally goes to REQ next cycle.
- REQ:
  - `inst_req`=1.
  - Redirect pending or arriving → REDIR; the request is withdrawn, which is legal because it was not yet accepted.
  - Otherwise `inst_addr_ok` → WAIT; `if_pc` latches `pc_q`.
- WAIT:
  - `inst_req`=0.
  - On `inst_data_ok`: if the cancel flag is set → REDIR and the data is dropped; else latch `if_inst` → VALID.
  - A redirect arriving in WAIT sets the cancel flag and latches the target; the state stays WAIT.
- VALID:
  - `if_valid`=1.
  - Redirect → REDIR; the instruction is discarded and `if_valid` falls the next cycle.
  - Otherwise `!stall_i` → `pc_en`=1 for that cycle → REQ.
  - `stall_i` → hold `if_valid`, `if_pc` and `if_inst` stable.
- REDIR: `pc_clr`=1, `pc_sd`=held target; then clear the pending and cancel flags → REQ.
- Redirect priority:
  - `exc_valid` beats `br_valid` in the same cycle.
  - A pending exception target is never overwritten by a later branch.
  - A later exception overwrites a pending branch.
  - A redirect arriving while in REDIR updates the target under the same rules and stays in REDIR one more cycle.
- `pc_en` and `pc_clr` are never both 1.
- `inst_req` is never 1 outside REQ.
- Address arithmetic: none inside the block; the PC+4 datapath stays external. Width is truncated to WIDTH.

## Timing
- Reset values: `pc_en`=0, `pc_clr`=0, `pc_sd`=RESET_PC, `inst_req`=0, `if_valid`=0, `if_pc`=RESET_PC, `if_inst`=0; cancel and pending flags clear.
- Reset deasserts → IDLE 1 cycle → `inst_req` high on cycle 2.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, VALID) when `addr_ok` and `data_ok` each arrive in the first eligible cycle.
- `inst_addr_ok` and `inst_data_ok` are sampled only in REQ and WAIT respectively; they are ignored elsewhere.
- `if_*` updates on the edge after `inst_data_ok`.
- PC register redirect takes effect on the edge after the REDIR cycle.
- Reset mid-fetch: all state clears asynchronously. Any late `inst_data_ok` arriving in IDLE/REQ is ignored.

## Configuration
- `FETCH_CTRL_PERF_EN` defined: two extra WIDTH-bit outputs.
  - `perf_fetch_cnt` counts VALID→REQ accepts.
  - `perf_cancel_cnt` counts dropped fetches (WAIT-with-cancel or VALID-with-redirect).
  - Both reset to 0 and wrap at 2^WIDTH.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t`.
  - `RESET_PC` default constant.
  - redirect-source encoding: NONE, BR, EXC.
- Sub-module `redirect_hold`: the priority merge plus the pending/cancel flags and the held target. The FSM, handshake and output registers stay in `fetch_ctrl`.

## Test plan
- Reset, then `addr_ok`/`data_ok` immediate with `stall_i`=0:
  - `inst_req` rises cycle 2.
  - `if_valid` pulses with `if_pc`=0.
  - `pc_en` pulses once per 3 cycles.
  - No `pc_clr`.
- `stall_i` held 4 cycles in VALID with `inst_rdata`=0x24020001: `if_inst` is stable for 4 cycles and `pc_en`=0 throughout; `pc_en`=1 on the first non-stall cycle.
- `br_valid` with target 0x100 during WAIT:
  - Returning data is dropped and `if_valid` stays 0.
  - Next cycle `pc_clr`=1 with `pc_sd`=0x100.
  - Then `inst_req` rises.
- Same-cycle `br_valid` (target 0x100) and `exc_valid` (target 0x380): `pc_sd`=0x380. A branch to 0x200 one cycle later does not change it.
- `rst_n` asserted while in WAIT, then a late `inst_data_ok` after release: ignored, and all outputs are at their reset values.
- With `FETCH_CTRL_PERF_EN`: 5 accepted fetches plus 2 cancelled fetches → `perf_fetch_cnt`=5, `perf_cancel_cnt`=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch-stage PC sequencer.
//   fetch_state_t    : FSM state encoding used by fetch_ctrl
//   redir_src_t      : source of the currently held redirect (none/branch/exception)
//   RESET_PC_DEFAULT : default PC value presented out of reset
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_VALID,
        ST_REDIR
    } fetch_state_t;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_BR,
        RD_EXC
    } redir_src_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/redirect_hold.sv
// redirect_hold: merges branch and exception redirect pulses into one held
// target with exception priority, and keeps the pending/cancel flags.
//   i_exc_valid/i_exc_target : exception redirect pulse and vector
//   i_br_valid/i_br_target   : branch redirect pulse and target
//   i_set_cancel             : mark the outstanding fetch as stale
//   i_clear                  : redirect has been applied; drop pending/cancel
//   o_pending                : a redirect is held and not yet applied
//   o_cancel                 : outstanding fetch must be discarded
//   o_arrive                 : a redirect pulse is present this cycle
//   o_target                 : held redirect target
module redirect_hold
    import fetch_pkg::*;
#(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_exc_valid,
    input  logic [WIDTH-1:0] i_exc_target,
    input  logic             i_br_valid,
    input  logic [WIDTH-1:0] i_br_target,
    input  logic             i_set_cancel,
    input  logic             i_clear,
    output logic             o_pending,
    output logic             o_cancel,
    output logic             o_arrive,
    output logic [WIDTH-1:0] o_target
);

    redir_src_t       r_src;
    logic [WIDTH-1:0] r_target;
    logic             r_cancel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src    <= RD_NONE;
            r_target <= RESET_PC;
            r_cancel <= 1'b0;
        end else begin
            // An exception always wins; a branch may only replace a branch.
            if (i_exc_valid) begin
                r_src    <= RD_EXC;
                r_target <= i_exc_target;
            end else if (i_br_valid && (r_src != RD_EXC)) begin
                r_src    <= RD_BR;
                r_target <= i_br_target;
            end else if (i_clear) begin
                r_src    <= RD_NONE;
            end

            if (i_set_cancel) begin
                r_cancel <= 1'b1;
            end else if (i_clear) begin
                r_cancel <= 1'b0;
            end
        end
    end

    assign o_pending = (r_src != RD_NONE);
    assign o_cancel  = r_cancel;
    assign o_arrive  = i_exc_valid | i_br_valid;
    assign o_target  = r_target;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer for the PC register. Runs the instruction
// memory request/response handshake, presents fetched instructions to decode
// and folds branch/exception redirects into one ordered PC update.
//   pc_en/pc_clr/pc_sd     : PC register advance, redirect load, redirect value
//   pc_q                   : current PC register value
//   inst_req/inst_addr     : fetch request and address (inst_addr == pc_q)
//   inst_addr_ok/data_ok   : memory accept and data-valid strobes
//   inst_rdata             : fetched word
//   if_valid/if_pc/if_inst : instruction presented to decode
//   stall_i                : decode back-pressure
//   exc_*/br_*             : redirect pulses and targets
// Optional build macro FETCH_CTRL_PERF_EN adds perf_fetch_cnt and
// perf_cancel_cnt counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_target,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] pc_q,
    output logic             pc_en,
    output logic             pc_clr,
    output logic [WIDTH-1:0] pc_sd,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_inst
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [WIDTH-1:0] perf_fetch_cnt,
    output logic [WIDTH-1:0] perf_cancel_cnt
`endif
);

    fetch_state_t     r_state;
    fetch_state_t     w_next;
    logic [WIDTH-1:0] r_if_pc;
    logic [WIDTH-1:0] r_if_inst;

    logic             w_latch_pc;
    logic             w_latch_inst;
    logic             w_clear;
    logic             w_set_cancel;
    logic             w_pending;
    logic             w_cancel;
    logic             w_arrive;
    logic             w_redir;
    logic [WIDTH-1:0] w_target;

    redirect_hold #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_redirect_hold (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_exc_valid  (exc_valid),
        .i_exc_target (exc_target),
        .i_br_valid   (br_valid),
        .i_br_target  (br_target),
        .i_set_cancel (w_set_cancel),
        .i_clear      (w_clear),
        .o_pending    (w_pending),
        .o_cancel     (w_cancel),
        .o_arrive     (w_arrive),
        .o_target     (w_target)
    );

    assign w_redir = w_arrive | w_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        pc_en        = 1'b0;
        pc_clr       = 1'b0;
        inst_req     = 1'b0;
        if_valid     = 1'b0;
        w_latch_pc   = 1'b0;
        w_latch_inst = 1'b0;
        w_clear      = 1'b0;
        w_set_cancel = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next = ST_REQ;
            end
            ST_REQ: begin
                inst_req = 1'b1;
                // Not yet accepted, so the request can simply be dropped.
                if (w_redir) begin
                    w_next = ST_REDIR;
                end else if (inst_addr_ok) begin
                    w_next     = ST_WAIT;
                    w_latch_pc = 1'b1;
                end
            end
            ST_WAIT: begin
                // The accepted fetch must still drain before redirecting.
                if (w_arrive) begin
                    w_set_cancel = 1'b1;
                end
                if (inst_data_ok) begin
                    if (w_cancel || w_arrive) begin
                        w_next = ST_REDIR;
                    end else begin
                        w_next       = ST_VALID;
                        w_latch_inst = 1'b1;
                    end
                end
            end
            ST_VALID: begin
                if_valid = 1'b1;
                if (w_redir) begin
                    w_next = ST_REDIR;
                end else if (!stall_i) begin
                    pc_en  = 1'b1;
                    w_next = ST_REQ;
                end
            end
            ST_REDIR: begin
                pc_clr = 1'b1;
                // A fresh redirect re-applies the merged target next cycle.
                if (!w_arrive) begin
                    w_clear = 1'b1;
                    w_next  = ST_REQ;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_pc   <= RESET_PC;
            r_if_inst <= '0;
        end else begin
            if (w_latch_pc) begin
                r_if_pc <= pc_q;
            end
            if (w_latch_inst) begin
                r_if_inst <= inst_rdata;
            end
        end
    end

    assign pc_sd     = w_target;
    assign inst_addr = pc_q;
    assign if_pc     = r_if_pc;
    assign if_inst   = r_if_inst;

`ifdef FETCH_CTRL_PERF_EN
    logic [WIDTH-1:0] r_perf_fetch;
    logic [WIDTH-1:0] r_perf_cancel;
    logic             w_drop;

    assign w_drop = ((r_state == ST_WAIT) && inst_data_ok && (w_cancel || w_arrive)) ||
                    ((r_state == ST_VALID) && w_redir);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch  <= '0;
            r_perf_cancel <= '0;
        end else begin
            if (pc_en) begin
                r_perf_fetch <= r_perf_fetch + WIDTH'(1);
            end
            if (w_drop) begin
                r_perf_cancel <= r_perf_cancel + WIDTH'(1);
            end
        end
    end

    assign perf_fetch_cnt  = r_perf_fetch;
    assign perf_cancel_cnt = r_perf_cancel;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [31:0] FIXED_INST = 32'h2402_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        br_valid;
    logic [31:0] br_target;
    logic [31:0] pc_q;
    logic        pc_en;
    logic        pc_clr;
    logic [31:0] pc_sd;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_cancel_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .exc_valid    (exc_valid),
        .exc_target   (exc_target),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .pc_q         (pc_q),
        .pc_en        (pc_en),
        .pc_clr       (pc_clr),
        .pc_sd        (pc_sd),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_cancel_cnt (perf_cancel_cnt)
`endif
    );

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    // External PC register: redirect load beats sequential +4 advance.
    logic [31:0] pc_model;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pc_model <= 32'h0;
        else if (pc_clr) pc_model <= pc_sd;
        else if (pc_en)  pc_model <= pc_model + 32'd4;
    end
    assign pc_q = pc_model;

    // Memory remembers the last accepted address and returns its word.
    logic [31:0] acc_addr = 32'h0;
    logic        use_fixed = 1'b0;
    logic        rd_junk = 1'b0;
    logic [31:0] junk_val = 32'h0;
    always @(posedge clk) begin
        if (inst_req && inst_addr_ok) acc_addr <= inst_addr;
    end
    assign inst_rdata = use_fixed ? FIXED_INST : (rd_junk ? junk_val : mem_word(acc_addr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc_en"},    {31'b0, pc_en},    32'h0);
        check({tag, "_pc_clr"},   {31'b0, pc_clr},   32'h0);
        check({tag, "_pc_sd"},    pc_sd,             32'h0);
        check({tag, "_inst_req"}, {31'b0, inst_req}, 32'h0);
        check({tag, "_if_valid"}, {31'b0, if_valid}, 32'h0);
        check({tag, "_if_pc"},    if_pc,             32'h0);
        check({tag, "_if_inst"},  if_inst,           32'h0);
    endtask

    initial begin
        int          en_cnt;
        int          clr_cnt;
        logic        e;
        logic        b;
        logic        outst;
        logic        prev_clr;
        logic        win_exc;
        logic        win_br;
        logic [31:0] win_exc_t;
        logic [31:0] win_br_t;
        logic        prev_hold;
        logic [31:0] prev_pc;
        logic [31:0] prev_inst;
        int          fetched;
        int          accepts;

        rst_n        = 1'b0;
        stall_i      = 1'b0;
        exc_valid    = 1'b0;
        exc_target   = 32'h0;
        br_valid     = 1'b0;
        br_target    = 32'h0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("rst");

        // Release: one IDLE cycle, request on the second cycle
        rst_n = 1'b1;
        #1;
        check("idle_no_req", {31'b0, inst_req}, 32'h0);
        tick();
        inst_addr_ok = 1'b1;
        inst_data_ok = 1'b1;
        #1;
        check("req_cycle2", {31'b0, inst_req}, 32'h1);
        check("req_addr0", inst_addr, 32'h0);
        tick();
        #1;
        check("wait_no_req", {31'b0, inst_req}, 32'h0);
        check("wait_no_valid", {31'b0, if_valid}, 32'h0);
        tick();
        #1;
        check("valid1", {31'b0, if_valid}, 32'h1);
        check("valid1_pc", if_pc, 32'h0);
        check("valid1_inst", if_inst, mem_word(32'h0));
        check("valid1_pc_en", {31'b0, pc_en}, 32'h1);
        check("valid1_no_clr", {31'b0, pc_clr}, 32'h0);

        // Best-case throughput: one pc_en per three cycles, no redirect
        en_cnt = 0;
        clr_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            #1;
            if (pc_en) en_cnt++;
            if (pc_clr) clr_cnt++;
        end
        check("thru_pc_en_cnt", en_cnt, 3);
        check("thru_pc_clr_cnt", clr_cnt, 0);

        // Decode stall for four cycles in VALID
        tick();
        use_fixed = 1'b1;
        #1;
        check("stall_req", {31'b0, inst_req}, 32'h1);
        check("stall_req_addr", inst_addr, 32'h10);
        tick();
        stall_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check("stall_valid", {31'b0, if_valid}, 32'h1);
            check("stall_inst", if_inst, FIXED_INST);
            check("stall_pc", if_pc, 32'h10);
            check("stall_no_pc_en", {31'b0, pc_en}, 32'h0);
        end
        tick();
        stall_i = 1'b0;
        #1;
        check("stall_release_pc_en", {31'b0, pc_en}, 32'h1);
        check("stall_release_inst", if_inst, FIXED_INST);

        // Branch during WAIT cancels the outstanding fetch
        tick();
        use_fixed = 1'b0;
        #1;
        check("br_req", {31'b0, inst_req}, 32'h1);
        tick();
        inst_data_ok = 1'b0;
        br_valid     = 1'b1;
        br_target    = 32'h100;
        #1;
        check("br_wait_no_req", {31'b0, inst_req}, 32'h0);
        check("br_wait_no_clr", {31'b0, pc_clr}, 32'h0);
        tick();
        br_valid     = 1'b0;
        inst_data_ok = 1'b1;
        #1;
        check("br_wait2_no_valid", {31'b0, if_valid}, 32'h0);
        tick();
        #1;
        check("br_redir_clr", {31'b0, pc_clr}, 32'h1);
        check("br_redir_sd", pc_sd, 32'h100);
        check("br_drop_no_valid", {31'b0, if_valid}, 32'h0);
        check("br_redir_no_en", {31'b0, pc_en}, 32'h0);
        tick();
        #1;
        check("br_req_after", {31'b0, inst_req}, 32'h1);
        check("br_req_addr", inst_addr, 32'h100);
        check("br_req_no_clr", {31'b0, pc_clr}, 32'h0);

        // Same-cycle exception and branch, then a later branch
        tick();
        inst_data_ok = 1'b0;
        exc_valid    = 1'b1;
        exc_target   = 32'h380;
        br_valid     = 1'b1;
        br_target    = 32'h100;
        #1;
        tick();
        exc_valid = 1'b0;
        br_target = 32'h200;
        #1;
        check("exc_prio_sd", pc_sd, 32'h380);
        tick();
        br_valid     = 1'b0;
        inst_data_ok = 1'b1;
        #1;
        check("exc_hold_sd", pc_sd, 32'h380);
        tick();
        #1;
        check("exc_redir_clr", {31'b0, pc_clr}, 32'h1);
        check("exc_redir_sd", pc_sd, 32'h380);
        check("exc_drop_no_valid", {31'b0, if_valid}, 32'h0);
        tick();
        #1;
        check("exc_req_addr", inst_addr, 32'h380);

        // Reset while WAIT, late data after release
        tick();
        inst_data_ok = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        tick();
        rst_n        = 1'b1;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        #1;
        check_reset_outputs("post_rst_idle");
        tick();
        #1;
        check("post_rst_req", {31'b0, inst_req}, 32'h1);
        check("late_data_no_valid", {31'b0, if_valid}, 32'h0);
        check("late_data_if_inst", if_inst, 32'h0);
        check("late_data_if_pc", if_pc, 32'h0);
        check("late_data_no_en", {31'b0, pc_en}, 32'h0);
        check("late_data_no_clr", {31'b0, pc_clr}, 32'h0);
        tick();
        inst_data_ok = 1'b0;
        #1;
        check("late_data_ignored", {31'b0, if_valid}, 32'h0);
        check("late_data_still_req", {31'b0, inst_req}, 32'h1);

        // Randomized traffic against the reference rules
        outst     = 1'b0;
        prev_clr  = 1'b0;
        win_exc   = 1'b0;
        win_br    = 1'b0;
        win_exc_t = 32'h0;
        win_br_t  = 32'h0;
        prev_hold = 1'b0;
        prev_pc   = 32'h0;
        prev_inst = 32'h0;
        fetched   = 0;
        accepts   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            e = ($urandom_range(0, 99) < 3);
            b = ($urandom_range(0, 99) < 6);
            exc_valid    = e;
            exc_target   = $urandom & 32'hFFFF_FFFC;
            br_valid     = b;
            br_target    = $urandom & 32'hFFFF_FFFC;
            stall_i      = ($urandom_range(0, 3) == 0);
            inst_addr_ok = inst_req && !e && !b && ($urandom_range(0, 1) == 1);
            inst_data_ok = outst && ($urandom_range(0, 2) == 0);
            rd_junk      = !inst_data_ok;
            junk_val     = $urandom;
            #1;

            // Once a redirect run ends, the PC holds the merged target:
            // latest exception if any, otherwise latest branch.
            if (prev_clr && !pc_clr) begin
                check("rnd_redir_target", pc_q, win_exc ? win_exc_t : win_br_t);
                check("rnd_redir_had_src", {31'b0, win_exc | win_br}, 32'h1);
                win_exc = 1'b0;
                win_br  = 1'b0;
            end
            prev_clr = pc_clr;
            if (e) begin
                win_exc   = 1'b1;
                win_exc_t = exc_target;
            end
            if (b) begin
                win_br   = 1'b1;
                win_br_t = br_target;
            end

            check("rnd_en_clr_excl", {31'b0, pc_en & pc_clr}, 32'h0);
            check("rnd_addr_eq_pc", inst_addr, pc_q);
            check("rnd_pc_en", {31'b0, pc_en}, {31'b0, if_valid && !stall_i && !e && !b});
            check("rnd_req_while_out", {31'b0, inst_req & outst}, 32'h0);
            if (if_valid) begin
                check("rnd_if_pc", if_pc, pc_q);
                check("rnd_if_inst", if_inst, mem_word(if_pc));
            end
            if (prev_hold) begin
                check("rnd_hold_valid", {31'b0, if_valid}, 32'h1);
                check("rnd_hold_pc", if_pc, prev_pc);
                check("rnd_hold_inst", if_inst, prev_inst);
            end
            prev_hold = if_valid && stall_i && !e && !b;
            prev_pc   = if_pc;
            prev_inst = if_inst;
            if (pc_en) fetched++;
            if (inst_req && inst_addr_ok) begin
                outst = 1'b1;
                accepts++;
            end else if (inst_data_ok) begin
                outst = 1'b0;
            end
        end

        tick();
        exc_valid    = 1'b0;
        br_valid     = 1'b0;
        stall_i      = 1'b1;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        #1;
        check("rnd_progress", {31'b0, fetched > 10}, 32'h1);
`ifdef FETCH_CTRL_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, fetched);
        check("perf_cancel_cnt", perf_cancel_cnt,
              accepts - fetched - int'(outst) - int'(if_valid));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
